// File: rtl/serial_alu_host.sv
// Front end for serial_alu: issues tagged ops and returns results in issue order, one cycle after alu_dout_vld.
// Requests stall on a busy issue register or when all DEPTH result slots are reserved. res_rdy never stalls the ALU.

module serial_alu_host_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full, do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full || do_pop);
  assign rdata_o = mem_q[rptr_q];

  always_comb begin
    wptr_d  = do_push ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = do_pop ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  overflow_a: assert property (@(posedge clock) disable iff (reset) !(push_i && full));
endmodule

module serial_alu_host #(
  parameter int DEPTH   = 4,
  parameter int TAGW    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [7:0]      req_di1,
  input  logic [7:0]      req_di2,
  input  logic [1:0]      req_fun,
  input  logic [TAGW-1:0] req_tag,
  input  logic            req_vld,
  output logic            req_rdy,
  output logic [7:0]      alu_di1,
  output logic [7:0]      alu_di2,
  output logic [1:0]      alu_fun,
  output logic            alu_vld,
  input  logic            alu_rdy,
  input  logic [7:0]      alu_dout,
  input  logic            alu_dout_vld,
  output logic [7:0]      res_dat,
  output logic [1:0]      res_fun,
  output logic [TAGW-1:0] res_tag,
  output logic            res_vld,
  input  logic            res_rdy,
  output logic            busy,
  output logic            err_spurious,
  output logic            err_timeout
);
  typedef struct packed { logic [TAGW-1:0] tag; logic [1:0] fun; } inflight_t;
  typedef struct packed { logic [7:0] dat; logic [1:0] fun; logic [TAGW-1:0] tag; } result_t;

  localparam int CW = $clog2(DEPTH + 1);
  localparam int WW = $clog2(TIMEOUT);

  logic [CW-1:0]   reserved_q, reserved_d;
  logic            alu_vld_q, alu_vld_d;
  logic [7:0]      alu_di1_q, alu_di1_d, alu_di2_q, alu_di2_d;
  logic [1:0]      alu_fun_q, alu_fun_d;
  logic [TAGW-1:0] alu_tag_q, alu_tag_d;
  logic [WW-1:0]   wd_q, wd_d;
  logic            err_spurious_q, err_spurious_d, err_timeout_q, err_timeout_d;
  logic            req_acc, res_pop, alu_acc, fl_empty, fl_pop, res_empty;
  inflight_t       fl_push_dat, fl_head;
  result_t         res_push_dat, res_head;

  // Depends only on registered state and alu_rdy, never on res_rdy.
  assign req_rdy = !reset && (!alu_vld_q || alu_rdy) && (reserved_q < CW'(DEPTH));
  assign req_acc = req_vld && req_rdy;
  assign alu_acc = alu_vld_q && alu_rdy;
  assign res_vld = !res_empty;
  assign res_pop = res_vld && res_rdy;
  assign fl_pop  = alu_dout_vld && !fl_empty;

  assign fl_push_dat  = '{tag: alu_tag_q, fun: alu_fun_q};
  assign res_push_dat = '{dat: alu_dout, fun: fl_head.fun, tag: fl_head.tag};

  serial_alu_host_fifo #(.WIDTH($bits(inflight_t)), .DEPTH(2)) u_inflight (
    .clock   (clock),
    .reset   (reset),
    .push_i  (alu_acc),
    .wdata_i (fl_push_dat),
    .pop_i   (fl_pop),
    .rdata_o (fl_head),
    .empty_o (fl_empty)
  );

  serial_alu_host_fifo #(.WIDTH($bits(result_t)), .DEPTH(DEPTH)) u_result (
    .clock   (clock),
    .reset   (reset),
    .push_i  (fl_pop),
    .wdata_i (res_push_dat),
    .pop_i   (res_pop),
    .rdata_o (res_head),
    .empty_o (res_empty)
  );

  always_comb begin
    reserved_d = reserved_q + CW'(req_acc) - CW'(res_pop);
    alu_vld_d  = alu_vld_q;
    alu_di1_d  = alu_di1_q;
    alu_di2_d  = alu_di2_q;
    alu_fun_d  = alu_fun_q;
    alu_tag_d  = alu_tag_q;
    if (req_acc) begin
      alu_vld_d = 1'b1;
      alu_di1_d = req_di1;
      alu_di2_d = req_di2;
      alu_fun_d = req_fun;
      alu_tag_d = req_tag;
    end else if (alu_acc) begin
      alu_vld_d = 1'b0;
    end
    // Watchdog saturates at its threshold so it cannot wrap while an op is stuck.
    if (fl_empty || alu_dout_vld) wd_d = '0;
    else if (wd_q != WW'(TIMEOUT - 1)) wd_d = wd_q + WW'(1);
    else wd_d = wd_q;
    err_spurious_d = err_spurious_q || (alu_dout_vld && fl_empty);
    err_timeout_d  = err_timeout_q || (!fl_empty && !alu_dout_vld && (wd_q == WW'(TIMEOUT - 1)));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      reserved_q     <= '0;
      alu_vld_q      <= 1'b0;
      alu_di1_q      <= '0;
      alu_di2_q      <= '0;
      alu_fun_q      <= '0;
      alu_tag_q      <= '0;
      wd_q           <= '0;
      err_spurious_q <= 1'b0;
      err_timeout_q  <= 1'b0;
    end else begin
      reserved_q     <= reserved_d;
      alu_vld_q      <= alu_vld_d;
      alu_di1_q      <= alu_di1_d;
      alu_di2_q      <= alu_di2_d;
      alu_fun_q      <= alu_fun_d;
      alu_tag_q      <= alu_tag_d;
      wd_q           <= wd_d;
      err_spurious_q <= err_spurious_d;
      err_timeout_q  <= err_timeout_d;
    end
  end

  assign alu_vld      = alu_vld_q;
  assign alu_di1      = alu_di1_q;
  assign alu_di2      = alu_di2_q;
  assign alu_fun      = alu_fun_q;
  assign res_dat      = res_head.dat;
  assign res_fun      = res_head.fun;
  assign res_tag      = res_head.tag;
  assign busy         = (reserved_q != '0);
  assign err_spurious = err_spurious_q;
  assign err_timeout  = err_timeout_q;
endmodule

// File: tb/tb_serial_alu_host.sv
// Bench for serial_alu_host: behavioural ALU model plus an in-order scoreboard of expected results.

module tb_serial_alu_host;
  localparam int DEPTH = 4, TAGW = 4, TIMEOUT = 15;
  typedef struct packed { logic [7:0] dat; logic [1:0] fun; logic [TAGW-1:0] tag; } res_t;

  logic clock = 1'b0, reset = 1'b1;
  logic [7:0] req_di1 = '0, req_di2 = '0;
  logic [1:0] req_fun = '0;
  logic [TAGW-1:0] req_tag = '0;
  logic req_vld = 1'b0, req_rdy;
  logic [7:0] alu_di1, alu_di2;
  logic [1:0] alu_fun;
  logic alu_vld, alu_rdy = 1'b0;
  logic [7:0] alu_dout = '0;
  logic alu_dout_vld = 1'b0;
  logic [7:0] res_dat;
  logic [1:0] res_fun;
  logic [TAGW-1:0] res_tag;
  logic res_vld, res_rdy = 1'b0, busy, err_spurious, err_timeout;

  int total = 0, bad = 0;
  int n_acc = 0, n_dout = 0, n_hs = 0;
  res_t exp_q[$], got_q[$];

  // ALU model configuration and state
  int alu_lat = 1, alu_cnt = 0;
  bit alu_lat_rand = 0, alu_rdy_rand = 0, alu_hold = 0, alu_spur = 0, alu_busy = 0;
  logic [7:0] alu_res = '0;

  serial_alu_host #(.DEPTH(DEPTH), .TAGW(TAGW), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .req_di1(req_di1), .req_di2(req_di2), .req_fun(req_fun), .req_tag(req_tag),
    .req_vld(req_vld), .req_rdy(req_rdy),
    .alu_di1(alu_di1), .alu_di2(alu_di2), .alu_fun(alu_fun), .alu_vld(alu_vld), .alu_rdy(alu_rdy),
    .alu_dout(alu_dout), .alu_dout_vld(alu_dout_vld),
    .res_dat(res_dat), .res_fun(res_fun), .res_tag(res_tag), .res_vld(res_vld), .res_rdy(res_rdy),
    .busy(busy), .err_spurious(err_spurious), .err_timeout(err_timeout)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] ref_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] f);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    case (f)
      2'd0: return s[7:0];
      2'd1: return a & b;
      2'd2: return a | b;
      default: return a ^ b;
    endcase
  endfunction

  // Runs at the falling edge: one serial op at a time, result pulsed after a latency.
  task automatic alu_step(input bit hs, input logic [7:0] a, input logic [7:0] b, input logic [1:0] f);
    alu_dout_vld = 1'b0;
    if (reset) begin
      alu_busy = 0;
      alu_rdy = 1'b0;
      return;
    end
    if (alu_spur) begin
      alu_dout_vld = 1'b1;
      alu_dout = 8'hAA;
      alu_spur = 0;
    end
    if (hs) begin
      alu_busy = 1;
      alu_cnt = alu_lat_rand ? int'($urandom_range(1, 4)) : alu_lat;
      alu_res = ref_op(a, b, f);
    end else if (alu_busy && !alu_hold) begin
      alu_cnt--;
      if (alu_cnt == 0) begin
        alu_dout_vld = 1'b1;
        alu_dout = alu_res;
        alu_busy = 0;
        n_dout++;
      end
    end
    alu_rdy = !alu_busy && (!alu_rdy_rand || ($urandom_range(0, 3) != 0));
  endtask

  // Called at negedge+1; records handshakes, advances one clock, returns at the next negedge+1.
  task automatic tick();
    res_t r;
    bit hs;
    logic [7:0] a, b;
    logic [1:0] f;
    if (!reset && req_vld && req_rdy) begin
      r.dat = ref_op(req_di1, req_di2, req_fun);
      r.fun = req_fun;
      r.tag = req_tag;
      exp_q.push_back(r);
      n_acc++;
    end
    if (!reset && res_vld && res_rdy) begin
      r.dat = res_dat;
      r.fun = res_fun;
      r.tag = res_tag;
      got_q.push_back(r);
    end
    hs = !reset && alu_vld && alu_rdy;
    a = alu_di1;
    b = alu_di2;
    f = alu_fun;
    if (hs) n_hs++;
    @(posedge clock);
    @(negedge clock);
    alu_step(hs, a, b, f);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req_vld = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    total++;
    if ({alu_vld, alu_di1, alu_di2, alu_fun, res_vld, req_rdy, busy, err_spurious, err_timeout} !== '0)
      begin bad++; $display("FAIL reset_values: got %b want all zero",
        {alu_vld, alu_di1, alu_di2, alu_fun, res_vld, req_rdy, busy, err_spurious, err_timeout}); end
    reset = 1'b0;
    tick();
    total++;
    if (req_rdy !== 1'b1 || busy !== 1'b0) begin bad++;
      $display("FAIL post_reset_rdy: req_rdy=%b busy=%b want 1 0", req_rdy, busy); end
  endtask

  task automatic test_single_op();
    bit seen = 0, prev = 0;
    res_rdy = 1'b1;
    alu_lat = 3;
    req_di1 = 8'h35; req_di2 = 8'h4A; req_fun = 2'd0; req_tag = 4'd3; req_vld = 1'b1;
    total++;
    if (req_rdy !== 1'b1) begin bad++; $display("FAIL single_req_rdy: got %b want 1", req_rdy); end
    tick();
    req_vld = 1'b0;
    total++;
    if ({alu_vld, alu_di1, alu_di2, alu_fun} !== {1'b1, 8'h35, 8'h4A, 2'd0}) begin bad++;
      $display("FAIL single_issue: vld=%b di1=%h di2=%h fun=%0d want 1 35 4a 0", alu_vld, alu_di1, alu_di2, alu_fun); end
    for (int i = 0; i < 20 && !seen; i++) begin
      if (res_vld) seen = 1;
      else begin prev = alu_dout_vld; tick(); end
    end
    total++;
    if (!seen || !prev) begin bad++; $display("FAIL single_latency: seen=%0d dout_prev=%0d want 1 1", seen, prev); end
    total++;
    if ({res_dat, res_fun, res_tag} !== {8'h7F, 2'd0, 4'd3}) begin bad++;
      $display("FAIL single_result: got %h/%0d/%0d want 7f/0/3", res_dat, res_fun, res_tag); end
    tick();
    total++;
    if (res_vld !== 1'b0 || busy !== 1'b0 || got_q.size() != 1) begin bad++;
      $display("FAIL single_one_cycle: res_vld=%b busy=%b pops=%0d want 0 0 1", res_vld, busy, got_q.size()); end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_order();
    logic [7:0] want [4];
    bit acc;
    want[0] = 8'h2C; want[1] = 8'h30; want[2] = 8'hFC; want[3] = 8'hCC;
    res_rdy = 1'b1;
    alu_lat = 1;
    for (int i = 0; i < 4; i++) begin
      req_di1 = 8'hF0; req_di2 = 8'h3C; req_fun = 2'(i); req_tag = TAGW'(i); req_vld = 1'b1;
      acc = 0;
      for (int c = 0; c < 50 && !acc; c++) begin acc = req_rdy; tick(); end
      total++;
      if (!acc) begin bad++; $display("FAIL order_accept_%0d: not accepted within bound", i); end
    end
    req_vld = 1'b0;
    for (int c = 0; c < 100 && got_q.size() < 4; c++) tick();
    total++;
    if (got_q.size() != 4) begin bad++; $display("FAIL order_count: got %0d results want 4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== {want[i], 2'(i), TAGW'(i)}) begin bad++;
        $display("FAIL order_result_%0d: got %h want %h", i, got_q[i], {want[i], 2'(i), TAGW'(i)}); end
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL order_busy: got %b want 0", busy); end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_credit();
    int start = n_acc;
    res_rdy = 1'b0;
    alu_lat = 2;
    req_vld = 1'b1;
    for (int c = 0; c < 60; c++) begin
      req_di1 = 8'($urandom); req_di2 = 8'($urandom); req_fun = 2'($urandom); req_tag = TAGW'(n_acc);
      tick();
    end
    total++;
    if (n_acc - start != 4 || req_rdy !== 1'b0 || busy !== 1'b1 || res_vld !== 1'b1) begin bad++;
      $display("FAIL credit_stall: acc=%0d rdy=%b busy=%b res_vld=%b want 4 0 1 1", n_acc - start, req_rdy, busy, res_vld); end
    res_rdy = 1'b1;
    tick();
    res_rdy = 1'b0;
    total++;
    if (req_rdy !== 1'b1 || got_q.size() != 1) begin bad++;
      $display("FAIL credit_release: rdy=%b pops=%0d want 1 1", req_rdy, got_q.size()); end
    tick();
    req_vld = 1'b0;
    total++;
    if (n_acc - start != 5) begin bad++; $display("FAIL credit_fifth: acc=%0d want 5", n_acc - start); end
    res_rdy = 1'b1;
    for (int c = 0; c < 100 && (got_q.size() < exp_q.size() || busy); c++) tick();
    total++;
    if (got_q.size() != 5 || exp_q.size() != 5) begin bad++;
      $display("FAIL credit_count: got %0d results want 5 (expected %0d)", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL credit_result_%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_random();
    int errs = 0;
    alu_lat_rand = 1;
    alu_rdy_rand = 1;
    for (int c = 0; c < 400; c++) begin
      req_vld = 1'($urandom_range(0, 1));
      req_di1 = 8'($urandom); req_di2 = 8'($urandom); req_fun = 2'($urandom); req_tag = TAGW'($urandom);
      res_rdy = ($urandom_range(0, 3) != 0);
      tick();
    end
    req_vld = 1'b0;
    res_rdy = 1'b1;
    for (int c = 0; c < 200 && (got_q.size() < exp_q.size() || busy); c++) tick();
    total++;
    if (exp_q.size() < 20 || got_q.size() != exp_q.size()) begin bad++;
      $display("FAIL random_count: got %0d results want %0d (min 20)", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        errs++;
        if (errs < 5) $display("FAIL random_result_%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    total++;
    if (err_spurious !== 1'b0 || err_timeout !== 1'b0 || busy !== 1'b0) begin bad++;
      $display("FAIL random_flags: spur=%b tmo=%b busy=%b want 0 0 0", err_spurious, err_timeout, busy); end
    alu_lat_rand = 0;
    alu_rdy_rand = 0;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_spurious();
    total++;
    if (err_spurious !== 1'b0) begin bad++; $display("FAIL spur_before: got %b want 0", err_spurious); end
    alu_spur = 1;
    tick();
    tick();
    total++;
    if (err_spurious !== 1'b1 || res_vld !== 1'b0) begin bad++;
      $display("FAIL spur_flag: err=%b res_vld=%b want 1 0", err_spurious, res_vld); end
    repeat (5) tick();
    total++;
    if (err_spurious !== 1'b1 || res_vld !== 1'b0 || err_timeout !== 1'b0) begin bad++;
      $display("FAIL spur_sticky: err=%b res_vld=%b tmo=%b want 1 0 0", err_spurious, res_vld, err_timeout); end
    apply_reset();
    total++;
    if (err_spurious !== 1'b0) begin bad++; $display("FAIL spur_cleared: got %b want 0", err_spurious); end
  endtask

  task automatic test_timeout();
    int h0 = n_hs;
    alu_hold = 1;
    res_rdy = 1'b1;
    req_di1 = 8'h01; req_di2 = 8'h02; req_fun = 2'd3; req_tag = 4'd9; req_vld = 1'b1;
    for (int c = 0; c < 20 && n_hs == h0; c++) begin
      tick();
      if (n_acc > 0) req_vld = 1'b0;
    end
    req_vld = 1'b0;
    total++;
    if (n_hs == h0) begin bad++; $display("FAIL timeout_issue: ALU never accepted the op"); end
    repeat (TIMEOUT - 1) tick();
    total++;
    if (err_timeout !== 1'b0) begin bad++; $display("FAIL timeout_early: got %b want 0 after 14 cycles", err_timeout); end
    tick();
    total++;
    if (err_timeout !== 1'b1) begin bad++; $display("FAIL timeout_set: got %b want 1 after 15 cycles", err_timeout); end
    repeat (10) tick();
    total++;
    if (err_timeout !== 1'b1 || busy !== 1'b1) begin bad++;
      $display("FAIL timeout_sticky: tmo=%b busy=%b want 1 1", err_timeout, busy); end
    alu_hold = 0;
    apply_reset();
    total++;
    if (err_timeout !== 1'b0 || busy !== 1'b0) begin bad++;
      $display("FAIL timeout_cleared: tmo=%b busy=%b want 0 0", err_timeout, busy); end
  endtask

  task automatic test_reset_mid_op();
    int a0 = n_acc, d0 = n_dout;
    bit ok = 0, acc = 0;
    res_rdy = 1'b0;
    alu_lat = 3;
    req_vld = 1'b1;
    for (int c = 0; c < 40 && n_acc - a0 < 3; c++) begin
      req_di1 = 8'($urandom); req_di2 = 8'($urandom); req_fun = 2'($urandom); req_tag = TAGW'(n_acc);
      tick();
    end
    req_vld = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin
      if (n_dout - d0 == 2 && alu_busy) ok = 1;
      else tick();
    end
    total++;
    if (!ok) begin bad++; $display("FAIL midop_setup: dout=%0d busy=%0d want 2 1", n_dout - d0, alu_busy); end
    reset = 1'b1;
    tick();
    total++;
    if ({alu_vld, alu_di1, alu_di2, alu_fun, res_vld, req_rdy, busy, err_spurious, err_timeout} !== '0)
      begin bad++; $display("FAIL midop_reset_values: got %b want all zero",
        {alu_vld, alu_di1, alu_di2, alu_fun, res_vld, req_rdy, busy, err_spurious, err_timeout}); end
    reset = 1'b0;
    exp_q.delete();
    got_q.delete();
    tick();
    res_rdy = 1'b1;
    req_di1 = 8'h12; req_di2 = 8'h34; req_fun = 2'd0; req_tag = 4'd5; req_vld = 1'b1;
    for (int c = 0; c < 20 && !acc; c++) begin acc = req_rdy; tick(); end
    req_vld = 1'b0;
    for (int c = 0; c < 40 && (got_q.size() < 1 || busy); c++) tick();
    total++;
    if (got_q.size() != 1 || err_spurious !== 1'b0) begin bad++;
      $display("FAIL midop_recover_count: got %0d results spur=%b want 1 0", got_q.size(), err_spurious); end
    else begin
      total++;
      if (got_q[0] !== {8'h46, 2'd0, 4'd5}) begin bad++;
        $display("FAIL midop_recover_result: got %h want %h", got_q[0], {8'h46, 2'd0, 4'd5}); end
    end
  endtask

  initial begin
    @(negedge clock);
    #1;
    test_reset();
    test_single_op();
    test_order();
    test_credit();
    test_random();
    test_spurious();
    test_timeout();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded its time limit");
    $fatal(1);
  end
endmodule

// File: doc/serial_alu_host.md
# serial_alu_host

Initiator-side front end for `serial_alu`: accepts tagged operation requests from a client, issues them over the ALU's `din_*` valid/ready port, collects the un-backpressured `dout_*` results, and returns them with tag and function code through a back-pressured result port. A credit scheme guarantees that no ALU result is ever dropped. Sticky error flags report protocol violations: spurious results and result timeouts.

## Interface
- `DEPTH`, default 4: result FIFO depth and credit pool size; power of two, ≥2.
- `TAGW`, default 4: width of the client tag.
- `TIMEOUT`, default 15: cycles an in-flight op may wait before `err_timeout` is set; must be ≥2.

Ports:
- `clock` in 1: clock; all logic on the rising edge.
- `reset` in 1: reset, synchronous, active-high.
- `req_di1`, `req_di2` in 8 each: operands.
- `req_fun` in 2: function code; 0 add, 1 and, 2 or, 3 xor.
- `req_tag` in TAGW: client tag, returned with the result.
- `req_vld` in 1, `req_rdy` out 1: request handshake.
- `alu_di1`, `alu_di2` out 8 each; `alu_fun` out 2: issue payload to the ALU.
- `alu_vld` out 1, `alu_rdy` in 1: issue handshake.
- `alu_dout` in 8, `alu_dout_vld` in 1: ALU result; a single-cycle pulse with no backpressure.
- `res_dat` out 8, `res_fun` out 2, `res_tag` out TAGW: result payload.
- `res_vld` out 1, `res_rdy` in 1: result handshake.
- `busy` out 1: at least one credit is reserved.
- `err_spurious` out 1, `err_timeout` out 1: sticky error flags, cleared only by reset.

## Operation
- **Credits**
  - `reserved` counter, range 0..DEPTH.
  - +1 on a request accept (`req_vld && req_rdy`).
  - −1 on a result pop (`res_vld && res_rdy`).
  - Both in the same cycle: counter unchanged.
- **Request acceptance**
  - `req_rdy = !reset && (!alu_vld || alu_rdy) && reserved < DEPTH`.
  - No combinational path from `res_rdy` to `req_rdy`.
- **Issue register**
  - Loaded on a request accept; drives `alu_*`.
  - `alu_vld` and payload hold stable until `alu_vld && alu_rdy`.
  - Accept and reload may happen in the same cycle, giving back-to-back issue.
- **In-flight queue**
  - Depth-2 FIFO of {tag, fun}.
  - Pushed on an ALU accept; popped on `alu_dout_vld`.
  - Depth 2 covers the ALU accepting the next op in the same cycle its previous result is emitted.
- **Result FIFO**
  - Depth DEPTH, show-ahead.
  - On `alu_dout_vld` with a non-empty in-flight queue: push {`alu_dout`, queue head}.
  - Credits guarantee the FIFO never overflows. An internal assertion fires on a push when full.
  - `res_vld = count != 0`. Push and pop in the same cycle are allowed at any count.
- **Spurious result**
  - `alu_dout_vld` while the in-flight queue is empty: set `err_spurious`, discard the data, FIFO unchanged.
- **Watchdog**
  - `wd` counter increments each cycle while the in-flight queue is non-empty.
  - Cleared on `alu_dout_vld` or when the queue is empty.
  - `wd == TIMEOUT-1` while still waiting: set `err_timeout`.
  - Ops are not aborted; recovery is by reset only.
- **Outputs**
  - `busy = reserved != 0`.
  - Results are returned strictly in issue order; tags are opaque and may repeat.

## Timing
- **Reset values:** `alu_vld`=0, `alu_di1`/`alu_di2`/`alu_fun`=0, `res_vld`=0, `req_rdy`=0, `busy`=0, `err_*`=0; all counters and FIFOs empty.
- **Latency, request accept (cycle t):** `alu_vld`=1 at t+1.
- **Latency, `alu_dout_vld` (cycle t):** `res_vld`=1 at t+1 if the FIFO was empty. Result path min latency = ALU latency + 1.
- **Throughput:** one op per ALU accept. With `res_rdy` held at 1 the host never stalls the ALU.
- **FIFO full:** `reserved == DEPTH` holds `req_rdy` at 0. A pop at t re-enables `req_rdy` at t+1.
- **Reset mid-operation:** all in-flight state is discarded at the next edge. The ALU shares `reset`, so no stale result arrives afterwards.
- **Illegal stimulus:** `alu_dout_vld` in the reset cycle is ignored.

## Test plan
- **Single op:** `req` {0x35, 0x4A, fun 0, tag 3}, `res_rdy`=1 → `alu_vld` the next cycle; one cycle after `alu_dout_vld`, `res_dat`=0x7F, `res_fun`=0, `res_tag`=3, `res_vld` for exactly one cycle.
- **Ordering and all functions:** 4 back-to-back requests, fun 0..3 with {0xF0, 0x3C}, tags 0..3 → results 0x2C, 0x30, 0xFC, 0xCC with tags 0..3 in order; `busy` drops to 0 after the last pop.
- **Credit stall:** `res_rdy`=0, 5 requests, DEPTH=4 → 4 accepted, `req_rdy`=0 with `reserved`=4; assert `res_rdy` for 1 cycle → 5th request accepted next cycle; no result lost.
- **Spurious result:** idle host, ALU model pulses `alu_dout_vld` with 0xAA → `err_spurious`=1 from the next cycle, `res_vld` stays 0.
- **Timeout:** ALU model accepts an op and withholds the result → `err_timeout`=1 after 15 cycles waiting; stays set until reset.
- **Reset mid-op:** reset asserted with 2 results queued and 1 in flight → the next cycle all outputs are at reset values, `reserved`=0, and a new request completes normally.
